vga_sync_gen: RTL and testbench
===============================

// Module: vga_sync_gen
// PURPOSE
//  Upstream timing stage for the rgb1 pixel/colour logic in vga_top_module.
//  Divides clk_main into a pixel-rate enable.
//  Runs the horizontal and vertical position counters.
//  Produces hsync/vsync, the active-video flag and line/frame strobes.
//  rgb1 consumes hcount/vcount as pixel coordinates and gates its colour with video_on.
// PARAMETERS
//  CLK_DIV   2    clk_main cycles per pixel (>=1; 2 gives 25 MHz from 50 MHz)
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch, pixels
//  H_SYNC    96   hsync pulse width, pixels
//  H_BP      48   horizontal back porch, pixels
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch, lines
//  V_SYNC    2    vsync pulse width, lines
//  V_BP      33   vertical back porch, lines
//  SYNC_POL  0    active level of hsync/vsync (0 = active-low)
// PORTS
//  clk_main     in   1   system clock; only clock in the block
//  rst          in   1   synchronous, active-high reset
//  hcount       out  11  pixel column, 0..H_TOTAL-1
//  vcount       out  10  line number, 0..V_TOTAL-1
//  hsync        out  1   horizontal sync, polarity per SYNC_POL
//  vsync        out  1   vertical sync, polarity per SYNC_POL
//  video_on     out  1   1 when hcount<H_ACTIVE and vcount<V_ACTIVE
//  pixel_tick   out  1   1-clk pulse each time the outputs advance one pixel
//  line_start   out  1   1-clk pulse coincident with hcount becoming 0
//  frame_start  out  1   1-clk pulse coincident with (hcount,vcount) becoming (0,0)
// BEHAVIOUR
//  Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
//  Divider: div_cnt counts 0..CLK_DIV-1 and wraps.
//   - tick_int = (div_cnt == CLK_DIV-1).
//   - CLK_DIV=1 gives tick_int every cycle.
//  Counters, advanced only on tick_int:
//   - h_cnt wraps H_TOTAL-1 -> 0.
//   - On that wrap, v_cnt increments; v_cnt wraps V_TOTAL-1 -> 0 on the same cycle.
//  Output stage (registered, 1 clk after internal counters):
//   - hcount/vcount/hsync/vsync/video_on load from the same h_cnt/v_cnt value.
//   - All outputs are therefore mutually aligned on every cycle.
//   - pixel_tick = registered tick_int, aligned with the output update.
//  Sync windows:
//   - hsync active for H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (656..751).
//   - vsync active for V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (490..491).
//   - Outside these windows each sync is at ~SYNC_POL.
//  Strobes:
//   - line_start pulses on the cycle outputs first show hcount=0.
//   - frame_start additionally requires vcount=0.
//   - Neither strobe pulses out of reset; the first pulse comes on the first wrap.
//  Reset, any cycle, including mid-line or mid-sync pulse:
//   - div_cnt, h_cnt, v_cnt = 0.
//   - hcount=0, vcount=0, video_on=0, pixel_tick=0, line_start=0, frame_start=0.
//   - hsync = vsync = ~SYNC_POL.
//   - After release, the first output advance comes CLK_DIV+1 clks later.
//  Widths: counters are sized to the ports; H_TOTAL<=2048 and V_TOTAL<=1024 are required.
//  No elaboration-time check is made on these limits.
// STRUCTURE
//  Shared package vga_pkg: default 640x480@60 timing constants and derived H_TOTAL/V_TOTAL.
//  rgb1 uses the same package for its coordinates.
//  One natural sub-module: vga_pix_div (divider producing tick_int).
//  Counters, decode and output registers stay in this module.
// TESTING
//  1. Defaults; hold rst 5 clks then release.
//     -> hcount=0, vcount=0, hsync=1, vsync=1, video_on=0 throughout reset.
//     -> First pixel_tick 3 clks after release.
//  2. Run one line.
//     -> hcount steps 0..799 every 2 clks.
//     -> hsync=0 exactly for hcount 656..751.
//     -> video_on=1 only for hcount 0..639 while vcount<480.
//  3. Run a full frame.
//     -> frame_start period = 840000 clks; line_start period = 1600 clks.
//     -> vsync=0 exactly for vcount 490..491.
//     -> video_on=0 for vcount 480..524.
//  4. Assert rst for 1 clk at hcount=700, inside the hsync pulse.
//     -> Next cycle: hsync=1, hcount=0, vcount=0, no line_start or frame_start pulse.
//  5. CLK_DIV=1, SYNC_POL=1.
//     -> pixel_tick is constantly 1 after reset.
//     -> hsync=1 only for hcount 656..751.
//     -> Frame period 420000 clks.
//  6. Wrap corner: at hcount=799, vcount=524.
//     -> Next advance gives (0,0), frame_start=1 and line_start=1 in the same cycle.

Source files
------------

// File: rtl/vga_pkg.sv
// Default 640x480@60 timing shared by the sync generator and the rgb1 pixel logic.
package vga_pkg;

  localparam int HCNT_W = 11;
  localparam int VCNT_W = 10;

  localparam int DEF_CLK_DIV  = 2;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam bit DEF_SYNC_POL = 1'b0;

  localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_pix_div.sv
// Pixel-rate enable: one-cycle tick every CLK_DIV clocks, free-running, no backpressure.
module vga_pix_div #(
  parameter int CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int            DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] r_div_cnt;
  logic          w_tick;

  assign w_tick = (r_div_cnt == LAST);
  assign o_tick = w_tick;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div_cnt <= '0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing: pixel enable, h/v position counters, syncs, video_on and line/frame strobes.
// Outputs are registered one clock after the internal counters; free-running, no backpressure.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = DEF_SYNC_POL
) (
  input  logic              clk_main,
  input  logic              rst,
  output logic [HCNT_W-1:0] hcount,
  output logic [VCNT_W-1:0] vcount,
  output logic              hsync,
  output logic              vsync,
  output logic              video_on,
  output logic              pixel_tick,
  output logic              line_start,
  output logic              frame_start
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HCNT_W-1:0] H_LAST   = HCNT_W'(H_TOT - 1);
  localparam logic [HCNT_W-1:0] H_ACT    = HCNT_W'(H_ACTIVE);
  localparam logic [HCNT_W-1:0] HS_START = HCNT_W'(H_ACTIVE + H_FP);
  localparam logic [HCNT_W-1:0] HS_END   = HCNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VCNT_W-1:0] V_LAST   = VCNT_W'(V_TOT - 1);
  localparam logic [VCNT_W-1:0] V_ACT    = VCNT_W'(V_ACTIVE);
  localparam logic [VCNT_W-1:0] VS_START = VCNT_W'(V_ACTIVE + V_FP);
  localparam logic [VCNT_W-1:0] VS_END   = VCNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic              w_tick;
  logic [HCNT_W-1:0] r_h_cnt;
  logic [VCNT_W-1:0] r_v_cnt;
  logic              r_adv;
  logic              w_hs_act;
  logic              w_vs_act;
  logic              w_vid;
  logic              w_h_zero;
  logic              w_v_zero;

  logic [HCNT_W-1:0] r_hcount;
  logic [VCNT_W-1:0] r_vcount;
  logic              r_hsync;
  logic              r_vsync;
  logic              r_video_on;
  logic              r_pixel_tick;
  logic              r_line_start;
  logic              r_frame_start;

  vga_pix_div #(
    .CLK_DIV(CLK_DIV)
  ) u_pix_div (
    .i_clk (clk_main),
    .i_rst (rst),
    .o_tick(w_tick)
  );

  always_ff @(posedge clk_main) begin
    if (rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
      r_adv   <= 1'b0;
    end else begin
      r_adv <= w_tick;
      if (w_tick) begin
        if (r_h_cnt == H_LAST) begin
          r_h_cnt <= '0;
          r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
        end else begin
          r_h_cnt <= r_h_cnt + 1'b1;
        end
      end
    end
  end

  assign w_hs_act = (r_h_cnt >= HS_START) && (r_h_cnt < HS_END);
  assign w_vs_act = (r_v_cnt >= VS_START) && (r_v_cnt < VS_END);
  assign w_vid    = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  assign w_h_zero = (r_h_cnt == '0);
  assign w_v_zero = (r_v_cnt == '0);

  // r_adv marks the first cycle a new position is held, so strobes never fire out of reset
  always_ff @(posedge clk_main) begin
    if (rst) begin
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_video_on    <= 1'b0;
      r_pixel_tick  <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_hcount      <= r_h_cnt;
      r_vcount      <= r_v_cnt;
      r_hsync       <= sync_level(w_hs_act, SYNC_POL);
      r_vsync       <= sync_level(w_vs_act, SYNC_POL);
      r_video_on    <= w_vid;
      r_pixel_tick  <= r_adv;
      r_line_start  <= r_adv && w_h_zero;
      r_frame_start <= r_adv && w_h_zero && w_v_zero;
    end
  end

  assign hcount      = r_hcount;
  assign vcount      = r_vcount;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign video_on    = r_video_on;
  assign pixel_tick  = r_pixel_tick;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default timing (line level), a shrunken timing for frame/wrap checks,
// and a CLK_DIV=1 / positive-sync variant.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic rst_c = 1'b1;

  logic [10:0] a_h, b_h, c_h;
  logic [9:0]  a_v, b_v, c_v;
  logic a_hs, a_vs, a_vid, a_pt, a_ls, a_fs;
  logic b_hs, b_vs, b_vid, b_pt, b_ls, b_fs;
  logic c_hs, c_vs, c_vid, c_pt, c_ls, c_fs;

  vga_sync_gen u_dut_a (
    .clk_main(clk), .rst(rst_a), .hcount(a_h), .vcount(a_v), .hsync(a_hs), .vsync(a_vs),
    .video_on(a_vid), .pixel_tick(a_pt), .line_start(a_ls), .frame_start(a_fs)
  );

  vga_sync_gen #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0)
  ) u_dut_b (
    .clk_main(clk), .rst(rst_b), .hcount(b_h), .vcount(b_v), .hsync(b_hs), .vsync(b_vs),
    .video_on(b_vid), .pixel_tick(b_pt), .line_start(b_ls), .frame_start(b_fs)
  );

  vga_sync_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b1)
  ) u_dut_c (
    .clk_main(clk), .rst(rst_c), .hcount(c_h), .vcount(c_v), .hsync(c_hs), .vsync(c_vs),
    .video_on(c_vid), .pixel_tick(c_pt), .line_start(c_ls), .frame_start(c_fs)
  );

  int checks = 0;
  int errors = 0;
  int sel    = 0;

  logic [10:0] obs_h;
  logic [9:0]  obs_v;
  logic obs_hs, obs_vs, obs_vid, obs_pt, obs_ls, obs_fs;

  always_comb begin
    obs_h = '0; obs_v = '0; obs_hs = 1'b0; obs_vs = 1'b0;
    obs_vid = 1'b0; obs_pt = 1'b0; obs_ls = 1'b0; obs_fs = 1'b0;
    case (sel)
      0: begin
        obs_h = a_h; obs_v = a_v; obs_hs = a_hs; obs_vs = a_vs;
        obs_vid = a_vid; obs_pt = a_pt; obs_ls = a_ls; obs_fs = a_fs;
      end
      1: begin
        obs_h = b_h; obs_v = b_v; obs_hs = b_hs; obs_vs = b_vs;
        obs_vid = b_vid; obs_pt = b_pt; obs_ls = b_ls; obs_fs = b_fs;
      end
      default: begin
        obs_h = c_h; obs_v = c_v; obs_hs = c_hs; obs_vs = c_vs;
        obs_vid = c_vid; obs_pt = c_pt; obs_ls = c_ls; obs_fs = c_fs;
      end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_rst(input logic v);
    case (sel)
      0:       rst_a = v;
      1:       rst_b = v;
      default: rst_c = v;
    endcase
  endtask

  // Hold reset, checking idle outputs, then release and wait for the first advance.
  task automatic reset_and_release(input int cycles, input int cd, input logic pol);
    set_rst(1'b1);
    repeat (cycles) begin
      @(negedge clk);
      check("rst_hcount", obs_h, 0);
      check("rst_vcount", obs_v, 0);
      check("rst_hsync", obs_hs, !pol);
      check("rst_vsync", obs_vs, !pol);
      check("rst_video_on", obs_vid, 0);
      check("rst_pixel_tick", obs_pt, 0);
      check("rst_line_start", obs_ls, 0);
      check("rst_frame_start", obs_fs, 0);
    end
    set_rst(1'b0);
    repeat (cd) begin
      @(negedge clk);
      check("pre_tick", obs_pt, 0);
      check("pre_hcount", obs_h, 0);
    end
    @(negedge clk);
  endtask

  // Reference model indexed by k = cycles since the first output advance (hcount=1).
  task automatic run_model(input int cd, input int ha, input int hfp, input int hs, input int hbp,
                           input int va, input int vfp, input int vs, input int vbp,
                           input logic pol, input int ncyc);
    int ht;
    int vt;
    int last_ls;
    int last_fs;
    ht = ha + hfp + hs + hbp;
    vt = va + vfp + vs + vbp;
    last_ls = -1;
    last_fs = -1;
    for (int k = 0; k < ncyc; k++) begin
      int   p;
      int   h;
      int   v;
      logic tk;
      logic hact;
      logic vact;
      p    = 1 + k / cd;
      h    = p % ht;
      v    = (p / ht) % vt;
      tk   = (k % cd) == 0;
      hact = (h >= ha + hfp) && (h < ha + hfp + hs);
      vact = (v >= va + vfp) && (v < va + vfp + vs);
      check("hcount", obs_h, h);
      check("vcount", obs_v, v);
      check("hsync", obs_hs, hact ? pol : !pol);
      check("vsync", obs_vs, vact ? pol : !pol);
      check("video_on", obs_vid, (h < ha) && (v < va));
      check("pixel_tick", obs_pt, tk);
      check("line_start", obs_ls, tk && (h == 0));
      check("frame_start", obs_fs, tk && (h == 0) && (v == 0));
      if (obs_ls) begin
        if (last_ls >= 0) check("line_period", k - last_ls, ht * cd);
        last_ls = k;
      end
      if (obs_fs) begin
        if (last_fs >= 0) check("frame_period", k - last_fs, ht * vt * cd);
        last_fs = k;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int guard;

    // Default timing: reset, first tick, two full lines including the line wrap.
    sel = 0;
    reset_and_release(5, 2, 1'b0);
    check("first_tick", obs_pt, 1);
    check("first_hcount", obs_h, 1);
    run_model(2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 3300);

    // Single-cycle reset landing inside the hsync pulse.
    guard = 0;
    while (obs_h != 11'd700 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("reach_h700", obs_h, 700);
    check("h700_hsync", obs_hs, 0);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    check("midrst_hsync", obs_hs, 1);
    check("midrst_hcount", obs_h, 0);
    check("midrst_vcount", obs_v, 0);
    check("midrst_line_start", obs_ls, 0);
    check("midrst_frame_start", obs_fs, 0);
    check("midrst_pixel_tick", obs_pt, 0);
    repeat (2) begin
      @(negedge clk);
      check("midrst_hold", obs_h, 0);
    end
    @(negedge clk);
    check("midrst_restart_tick", obs_pt, 1);
    check("midrst_restart_h", obs_h, 1);

    // Shrunken timing: two full frames, frame wrap with both strobes.
    sel = 1;
    reset_and_release(4, 2, 1'b0);
    run_model(2, 8, 2, 3, 2, 6, 2, 2, 3, 1'b0, 800);

    // CLK_DIV=1 with active-high syncs.
    sel = 2;
    reset_and_release(3, 1, 1'b1);
    run_model(1, 8, 2, 3, 2, 6, 2, 2, 3, 1'b1, 400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
